// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key schedule sequencer: loads a cipher key, steps an external
// combinational expansion stage ten times and holds the 11 round keys for readout.
module aes128_key_sched_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] xp_key,
    output logic [3:0]   xp_count,
    input  logic [127:0] xp_key_out,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         keys_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);
    localparam logic [3:0] MAX_ADDR = 4'(ROUNDS);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   cur_q, cur_d;
    logic           keys_valid_q, keys_valid_d;
    logic           done_q, done_d;
    logic [127:0]   rk_data_q;
    logic [127:0]   rk_q [0:ROUNDS];

    logic           wr_en_s;
    logic [3:0]     wr_idx_s;
    logic [127:0]   wr_data_s;
    logic [127:0]   rd_sel_s;

    // Next-state logic and round-key write request
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = 4'd0;
        wr_data_s    = 128'd0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    wr_en_s      = 1'b1;
                    wr_idx_s     = 4'd0;
                    wr_data_s    = key_in;
                    cur_d        = key_in;
                    cnt_d        = 4'd0;
                    keys_valid_d = 1'b0;
                    state_d      = ST_EXPAND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = cnt_q + 4'd1;
                wr_data_s = xp_key_out;
                cur_d     = xp_key_out;
                if (cnt_q == LAST_CNT) begin
                    state_d      = ST_IDLE;
                    cnt_d        = 4'd0;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control and expansion-input registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            cur_q        <= 128'd0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
        end
    end

    // Round-key register file, one write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ROUNDS; i++) begin
                rk_q[i] <= 128'd0;
            end
        end else if (wr_en_s) begin
            rk_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Out-of-range read addresses return zero rather than aliasing
    always_comb begin
        if (rk_addr <= MAX_ADDR) begin
            rd_sel_s = rk_q[rk_addr];
        end else begin
            rd_sel_s = 128'd0;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_data_q <= 128'd0;
        end else begin
            rk_data_q <= rd_sel_s;
        end
    end

    assign key_ready  = (state_q == ST_IDLE) && !rst;
    assign xp_key     = cur_q;
    assign xp_count   = cnt_q;
    assign rk_data    = rk_data_q;
    assign keys_valid = keys_valid_q;
    assign busy       = (state_q == ST_EXPAND);
    assign done       = done_q;

endmodule
